// File: rtl/dda_multiaxis_timer_if.sv
// Move-buffer interface between the SPI move-buffer state machine (master)
// and the DDA step timer (slave).
//   clock_divisor       tick period minus one, in CLK cycles
//   move_duration       ticks-1 of the slot being loaded
//   increment           packed signed start velocities, axis i at [i*ACC_W +: ACC_W]
//   incrementincrement  packed signed per-tick velocity deltas, same packing
//   stepready           writer toggle per slot
//   stepfinished        timer toggle per slot; a slot is pending while the bits differ
//   moveind             slot the timer is loading or executing
//   writemoveind        writer cursor, adopted by the timer on halt
//   halt                active-low abort
interface dda_multiaxis_timer_if #(
  parameter int NUM_AXES = 3,
  parameter int DEPTH    = 2,
  parameter int ACC_W    = 64,
  parameter int DUR_W    = 64,
  parameter int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
);
  logic [7:0]                clock_divisor;
  logic [DUR_W-1:0]          move_duration;
  logic [NUM_AXES*ACC_W-1:0] increment;
  logic [NUM_AXES*ACC_W-1:0] incrementincrement;
  logic [DEPTH-1:0]          stepready;
  logic [DEPTH-1:0]          stepfinished;
  logic [IDX_W-1:0]          moveind;
  logic [IDX_W-1:0]          writemoveind;
  logic                      halt;

  modport master (
    output clock_divisor, move_duration, increment, incrementincrement,
           stepready, writemoveind, halt,
    input  stepfinished, moveind
  );

  modport slave (
    input  clock_divisor, move_duration, increment, incrementincrement,
           stepready, writemoveind, halt,
    output stepfinished, moveind
  );
endinterface

// File: rtl/dda_multiaxis_timer.sv
// Multi-axis DDA step generator driven from a ring of move slots.
// Each move runs NUM_AXES DDA channels for move_duration+1 ticks; each channel
// emits a one-cycle step pulse plus a held direction bit.
//   CLK        system clock
//   reset      synchronous, active-high
//   bus        move-buffer interface (slave side)
//   step       one-cycle step pulse per axis
//   dir        1 = forward, held until the axis steps again
//   move_done  one-cycle pulse when a slot completes
//   busy       high while loading or running a move
//
// state  | meaning
// S_IDLE | waiting for slot moveind to become pending
// S_LOAD | one cycle: latch duration, velocities, deltas and divider
// S_RUN  | dividing CLK into ticks and stepping the DDA channels
module dda_multiaxis_timer #(
  parameter int NUM_AXES = 3,
  parameter int DEPTH    = 2,
  parameter int ACC_W    = 64,
  parameter int DUR_W    = 64,
  parameter int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  CLK,
  input  logic                  reset,
  dda_multiaxis_timer_if.slave  bus,
  output logic [NUM_AXES-1:0]   step,
  output logic [NUM_AXES-1:0]   dir,
  output logic                  move_done,
  output logic                  busy
);

  // Thresholds are kept one bit wider than the accumulator so acc+vel never wraps.
  localparam logic signed [ACC_W:0] C_T    = {2'b00, 1'b1, {(ACC_W-2){1'b0}}};
  localparam logic signed [ACC_W:0] C_ONE  = {{ACC_W{1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] C_2T   = C_T + C_T;
  localparam logic signed [ACC_W:0] C_NT   = -C_T;
  localparam logic signed [ACC_W:0] C_VMAX = C_T - C_ONE;
  localparam logic signed [ACC_W:0] C_VMIN = -C_VMAX;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t r_state, w_state_nxt;

  logic [DEPTH-1:0]          r_stepfinished;
  logic [IDX_W-1:0]          r_moveind;
  logic [DUR_W-1:0]          r_tickdown;
  logic [7:0]                r_clkaccum;
  logic signed [ACC_W-1:0]   r_acc    [NUM_AXES];
  logic signed [ACC_W-1:0]   r_vel    [NUM_AXES];
  logic signed [ACC_W-1:0]   r_incinc [NUM_AXES];
  logic [NUM_AXES-1:0]       r_step;
  logic [NUM_AXES-1:0]       r_dir;
  logic                      r_move_done;

  logic                      w_pending;
  logic                      w_tick;
  logic                      w_last_tick;
  logic [IDX_W-1:0]          w_moveind_inc;
  logic signed [ACC_W:0]     w_sum    [NUM_AXES];
  logic signed [ACC_W:0]     w_wrap   [NUM_AXES];
  logic signed [ACC_W:0]     w_vsum   [NUM_AXES];
  logic signed [ACC_W:0]     w_vsat   [NUM_AXES];
  logic signed [ACC_W-1:0]   w_acc_nxt[NUM_AXES];
  logic signed [ACC_W-1:0]   w_vel_nxt[NUM_AXES];
  logic [NUM_AXES-1:0]       w_step_nxt;
  logic [NUM_AXES-1:0]       w_dir_nxt;

  function automatic logic signed [ACC_W:0] sext(input logic [ACC_W-1:0] x);
    return $signed({x[ACC_W-1], x});
  endfunction

  // A cursor parked beyond the last slot (possible via halt when DEPTH is not
  // a power of two) never reports a pending slot.
  always_comb begin
    w_pending = 1'b0;
    if (int'(r_moveind) < DEPTH)
      w_pending = (r_stepfinished[r_moveind] != bus.stepready[r_moveind]);
    w_moveind_inc = (int'(r_moveind) == DEPTH - 1) ? '0 : r_moveind + 1'b1;
    w_tick        = (r_state == S_RUN) && (r_clkaccum == 8'd0);
    w_last_tick   = w_tick && (r_tickdown == '0);
  end

  always_comb begin
    for (int i = 0; i < NUM_AXES; i++) begin
      w_sum[i]      = sext(r_acc[i]) + sext(r_vel[i]);
      w_wrap[i]     = w_sum[i];
      w_step_nxt[i] = 1'b0;
      w_dir_nxt[i]  = r_dir[i];
      if (w_sum[i] >= C_T) begin
        w_wrap[i]     = w_sum[i] - C_2T;
        w_step_nxt[i] = 1'b1;
        w_dir_nxt[i]  = 1'b1;
      end else if (w_sum[i] < C_NT) begin
        w_wrap[i]     = w_sum[i] + C_2T;
        w_step_nxt[i] = 1'b1;
        w_dir_nxt[i]  = 1'b0;
      end
      w_acc_nxt[i] = w_wrap[i][ACC_W-1:0];

      w_vsum[i] = sext(r_vel[i]) + sext(r_incinc[i]);
      w_vsat[i] = w_vsum[i];
      if (w_vsum[i] > C_VMAX)
        w_vsat[i] = C_VMAX;
      else if (w_vsum[i] < C_VMIN)
        w_vsat[i] = C_VMIN;
      w_vel_nxt[i] = w_vsat[i][ACC_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: if (w_pending) w_state_nxt = S_LOAD;
      S_LOAD: begin
        busy        = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last_tick) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!bus.halt) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_stepfinished <= '0;
      r_moveind      <= '0;
      r_tickdown     <= '0;
      r_clkaccum     <= '0;
      r_step         <= '0;
      r_dir          <= '0;
      r_move_done    <= 1'b0;
      for (int i = 0; i < NUM_AXES; i++) begin
        r_acc[i]    <= '0;
        r_vel[i]    <= '0;
        r_incinc[i] <= '0;
      end
    end else if (!bus.halt) begin
      // Abort: resynchronise to the writer, keep accumulators and directions.
      r_moveind      <= bus.writemoveind;
      r_stepfinished <= bus.stepready;
      r_step         <= '0;
      r_move_done    <= 1'b0;
    end else begin
      r_step      <= '0;
      r_move_done <= 1'b0;
      case (r_state)
        S_LOAD: begin
          r_tickdown <= bus.move_duration;
          r_clkaccum <= bus.clock_divisor;
          for (int i = 0; i < NUM_AXES; i++) begin
            r_vel[i]    <= bus.increment[i*ACC_W +: ACC_W];
            r_incinc[i] <= bus.incrementincrement[i*ACC_W +: ACC_W];
          end
        end
        S_RUN: begin
          if (w_tick) begin
            r_clkaccum <= bus.clock_divisor;
            r_tickdown <= r_tickdown - 1'b1;
            r_step     <= w_step_nxt;
            r_dir      <= w_dir_nxt;
            for (int i = 0; i < NUM_AXES; i++) begin
              r_acc[i] <= w_acc_nxt[i];
              r_vel[i] <= w_vel_nxt[i];
            end
            if (w_last_tick) begin
              r_stepfinished[r_moveind] <= ~r_stepfinished[r_moveind];
              r_moveind                 <= w_moveind_inc;
              r_move_done               <= 1'b1;
            end
          end else begin
            r_clkaccum <= r_clkaccum - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stepfinished = r_stepfinished;
  assign bus.moveind      = r_moveind;
  assign step             = r_step;
  assign dir              = r_dir;
  assign move_done        = r_move_done;

endmodule

// File: tb/tb_dda_multiaxis_timer.sv
module tb_dda_multiaxis_timer;
  localparam int NA    = 2;
  localparam int DEPTH = 3;
  localparam int ACC_W = 8;
  localparam int DUR_W = 8;
  localparam int IDX_W = 2;
  localparam int T     = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NA-1:0] step, dir;
  logic          move_done, busy;

  always #5 clk = ~clk;

  dda_multiaxis_timer_if #(.NUM_AXES(NA), .DEPTH(DEPTH), .ACC_W(ACC_W),
                           .DUR_W(DUR_W), .IDX_W(IDX_W)) bus ();

  dda_multiaxis_timer #(.NUM_AXES(NA), .DEPTH(DEPTH), .ACC_W(ACC_W),
                        .DUR_W(DUR_W), .IDX_W(IDX_W)) dut (
    .CLK(clk), .reset(reset), .bus(bus), .step(step), .dir(dir),
    .move_done(move_done), .busy(busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard entry: an edge at which the DUT must show step/move_done activity.
  typedef struct {int ev_edge; int stp; int dr; int done;} ev_t;
  ev_t sb[$];

  // Reference state, kept as plain integers.
  int m_acc[NA];
  int m_dir, m_sr, m_sf, m_mi, m_writer;
  int b_div[DEPTH], b_dur[DEPTH];
  int b_inc[DEPTH][NA], b_ii[DEPTH][NA];

  // Move j becomes visible as pending at edge c: LOAD at c+1, tick k at
  // c+2+div+k*(div+1). Ticks at or after 'cutoff' (halt/reset) never happen.
  task automatic model_move(input int c, input int j, input int cutoff,
                            output int x_edge);
    int vel[NA];
    int e, sum, st, dn;
    x_edge = c;
    for (int a = 0; a < NA; a++) vel[a] = b_inc[j][a];
    if (c + 1 >= cutoff) return;
    for (int k = 0; k <= b_dur[j]; k++) begin
      e = c + 2 + b_div[j] + k * (b_div[j] + 1);
      if (e >= cutoff) return;
      st = 0;
      for (int a = 0; a < NA; a++) begin
        sum = m_acc[a] + vel[a];
        if (sum >= T) begin
          m_acc[a] = sum - 2*T; st |= (1 << a); m_dir |= (1 << a);
        end else if (sum < -T) begin
          m_acc[a] = sum + 2*T; st |= (1 << a); m_dir &= ~(1 << a);
        end else begin
          m_acc[a] = sum;
        end
        vel[a] = vel[a] + b_ii[j][a];
        if (vel[a] > T-1) vel[a] = T-1;
        if (vel[a] < -(T-1)) vel[a] = -(T-1);
      end
      dn = (k == b_dur[j]) ? 1 : 0;
      if (dn != 0) begin
        m_sf ^= (1 << m_mi);
        m_mi = (m_mi + 1) % DEPTH;
        x_edge = e;
      end
      if (st != 0 || dn != 0) sb.push_back('{e, st, m_dir, dn});
    end
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic drive_params(input int j);
    bus.clock_divisor = 8'(b_div[j]);
    bus.move_duration = DUR_W'(b_dur[j]);
    for (int a = 0; a < NA; a++) begin
      bus.increment[a*ACC_W +: ACC_W]          = ACC_W'(b_inc[j][a]);
      bus.incrementincrement[a*ACC_W +: ACC_W] = ACC_W'(b_ii[j][a]);
    end
  endtask

  // Only move_duration/increment/incrementincrement are scrambled while running.
  task automatic drive_garbage();
    bus.move_duration      = DUR_W'($urandom);
    bus.increment          = (NA*ACC_W)'($urandom);
    bus.incrementincrement = (NA*ACC_W)'($urandom);
  endtask

  task automatic set_move(input int j, input int div, input int dur,
                          input int i0, input int i1, input int d0, input int d1);
    b_div[j] = div; b_dur[j] = dur;
    b_inc[j][0] = i0; b_inc[j][1] = i1;
    b_ii[j][0] = d0;  b_ii[j][1] = d1;
  endtask

  task automatic end_checks(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_stepfinished"}, bus.stepfinished, m_sf);
    chk({tag, "_moveind"}, bus.moveind, m_mi);
    chk({tag, "_sb_drained"}, sb.size(), 0);
  endtask

  // mode 0: run n moves to completion; 1: halt at edge e0+1+stop_off;
  // 2: reset at that edge. Stopped batches use n=1 and stop_off>=2.
  task automatic run_batch(input int n, input int mode, input int stop_off);
    int e0, c, cutoff, x, nsr;
    e0 = cyc;
    for (int j = 0; j < n; j++) begin
      m_sr ^= (1 << m_writer);
      m_writer = (m_writer + 1) % DEPTH;
    end
    drive_params(0);
    bus.stepready = DEPTH'(m_sr);
    c = e0 + 1;
    cutoff = (mode != 0) ? e0 + 1 + stop_off : 32'h7fff_ffff;
    x = c;
    for (int j = 0; j < n; j++) begin
      wait_until(c);
      drive_params(j);
      model_move(c, j, cutoff, x);
      wait_until(c + 1);
      drive_garbage();
      c = x + 1;
    end
    if (mode == 0) begin
      wait_until(x + 1);
      end_checks("done");
    end else begin
      wait_until(cutoff - 1);
      nsr = 0;
      if (mode == 1) begin
        nsr = int'($urandom_range(0, 7));
        bus.halt = 1'b0;
        bus.writemoveind = 2'd2;
        bus.stepready = DEPTH'(nsr);
      end else begin
        reset = 1'b1;
        bus.stepready = '0;
      end
      wait_until(cutoff);
      bus.halt = 1'b1;
      reset = 1'b0;
      m_sr = nsr; m_sf = nsr;
      if (mode == 1) begin
        m_mi = 2; m_writer = 2;
      end else begin
        m_mi = 0; m_writer = 0; m_dir = 0;
        for (int a = 0; a < NA; a++) m_acc[a] = 0;
      end
      chk("stop_step", step, 0);
      chk("stop_move_done", move_done, 0);
      chk("stop_dir", dir, m_dir);
      end_checks("stop");
      @(negedge clk);
      chk("stop_stays_idle", busy, 0);
    end
  endtask

  bit mon_en = 1'b0;
  initial begin
    ev_t ev;
    forever begin
      @(negedge clk);
      if (mon_en && (step != '0 || move_done)) begin
        if (sb.size() == 0) begin
          chk("unexpected_step", step, 0);
          chk("unexpected_move_done", move_done, 0);
        end else begin
          ev = sb.pop_front();
          chk("ev_cycle", cyc, ev.ev_edge);
          chk("ev_step", step, ev.stp);
          chk("ev_dir", dir, ev.dr);
          chk("ev_move_done", move_done, ev.done);
        end
      end
    end
  end

  initial begin
    int n, mode, off;
    bus.halt = 1'b1;
    bus.stepready = '0;
    bus.writemoveind = '0;
    bus.clock_divisor = '0;
    bus.move_duration = '0;
    bus.increment = '0;
    bus.incrementincrement = '0;
    m_dir = 0; m_sr = 0; m_sf = 0; m_mi = 0; m_writer = 0;
    for (int a = 0; a < NA; a++) m_acc[a] = 0;

    repeat (3) @(negedge clk);
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 0);
    chk("rst_move_done", move_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stepfinished", bus.stepfinished, 0);
    chk("rst_moveind", bus.moveind, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Empty buffer: nothing happens.
    repeat (4) begin
      @(negedge clk);
      chk("empty_busy", busy, 0);
    end

    set_move(0, 0, 9, 32, 0, 0, 0);    run_batch(1, 0, 0);
    set_move(0, 0, 9, -32, 0, 0, 0);   run_batch(1, 0, 0);
    set_move(0, 3, 0, 10, -10, 0, 0);  run_batch(1, 0, 0);
    set_move(0, 0, 4, 50, -20, 0, 0);
    set_move(1, 1, 3, -40, 33, 2, -3);
    set_move(2, 2, 2, 63, -63, -5, 5);
    run_batch(3, 0, 0);
    set_move(0, 0, 20, 60, -60, 10, -10); run_batch(1, 0, 0);
    set_move(0, 1, 15, 20, -30, 1, -1);   run_batch(1, 1, 12);

    for (int it = 0; it < 30; it++) begin
      mode = ($urandom_range(0, 5) == 0) ? 1 : 0;
      n = (mode != 0) ? 1 : int'($urandom_range(1, DEPTH));
      for (int j = 0; j < n; j++)
        set_move(j, int'($urandom_range(0, 3)), int'($urandom_range(0, 10)),
                 int'($urandom_range(0, 126)) - 63, int'($urandom_range(0, 126)) - 63,
                 int'($urandom_range(0, 16)) - 8, int'($urandom_range(0, 16)) - 8);
      off = 2 + int'($urandom_range(0, b_div[0] + b_dur[0] * (b_div[0] + 1)));
      run_batch(n, mode, off);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Halt on the completing tick: no move_done.
    set_move(0, 0, 5, 45, -45, 0, 0);  run_batch(1, 1, 7);
    // Reset in the middle of a move, then prove the accumulators restarted.
    set_move(0, 0, 20, 37, -50, 0, 0); run_batch(1, 2, 10);
    set_move(0, 0, 6, 40, -40, 0, 0);  run_batch(1, 0, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
